// File: rtl/bank_htu_pkg.sv
// Shared types for the bank HTU victim allocator: way one-hot vector and the allocation FSM states.
package bank_htu_pkg;

  localparam int WAYS = 8;

  typedef logic [WAYS-1:0] way_oh_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PICK = 2'd1,
    ST_RESP = 2'd2
  } alloc_state_e;

  function automatic logic onehot0(input way_oh_t v);
    return (v & (v - way_oh_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/bank_htu_prio_onehot.sv
// Lowest-index one-hot picker: keeps only the least significant set bit of the request vector.
module bank_htu_prio_onehot (
  input  logic [7:0] i_req,
  output logic [7:0] o_onehot
);

  // Two's complement isolates the lowest set bit; zero input gives zero output.
  assign o_onehot = i_req & (~i_req + 8'd1);

endmodule

// File: rtl/bank_htu_victim_alloc.sv
// Victim allocator for one set of the 8-way bank HTU: chooses and locks a victim way per request,
// tracks valid/lock state, and arbitrates single-touch-per-cycle access into the PLRU tree.
module bank_htu_victim_alloc #(
  parameter int WAYS        = 8,
  parameter bit ALLOC_TOUCH = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alloc_req_vld_i,
  output logic            alloc_req_rdy_o,
  output logic            alloc_rsp_vld_o,
  input  logic            alloc_rsp_rdy_i,
  output logic [WAYS-1:0] alloc_rsp_way_o,
  output logic            alloc_rsp_evict_o,
  input  logic [WAYS-1:0] way_dirty_i,
  input  logic            hit_vld_i,
  input  logic [WAYS-1:0] hit_way_i,
  input  logic            fill_done_vld_i,
  input  logic [WAYS-1:0] fill_done_way_i,
  input  logic            inval_vld_i,
  input  logic [WAYS-1:0] inval_way_i,
  input  logic [WAYS-1:0] oldest_way_array_i,
  output logic [WAYS-1:0] access_array_o,
  output logic [WAYS-1:0] way_locked_o
);

  import bank_htu_pkg::*;

  alloc_state_e r_state;
  alloc_state_e w_state_nxt;

  way_oh_t r_valid;
  way_oh_t r_lock;
  way_oh_t r_victim;
  logic    r_evict;
  logic    r_touch_pend;

  way_oh_t w_cand_inv;
  way_oh_t w_cand_fb;
  way_oh_t w_pick_inv;
  way_oh_t w_pick_fb;
  way_oh_t w_oldest_ok;
  way_oh_t w_victim;
  way_oh_t w_lock_set;
  way_oh_t w_fill_eff;
  way_oh_t w_inval_mask;
  logic    w_has_cand;
  logic    w_evict;
  logic    w_rsp_fire;
  logic    w_touch_issue;

  assign w_cand_inv  = ~r_valid & ~r_lock;
  assign w_cand_fb   = r_valid & ~r_lock;
  assign w_oldest_ok = oldest_way_array_i & ~r_lock;
  assign w_has_cand  = |(~r_lock);

  bank_htu_prio_onehot u_prio_inv (
    .i_req    (w_cand_inv),
    .o_onehot (w_pick_inv)
  );

  bank_htu_prio_onehot u_prio_fb (
    .i_req    (w_cand_fb),
    .o_onehot (w_pick_fb)
  );

  // Empty ways first, then the PLRU choice if it is free, else the lowest unlocked valid way.
  always_comb begin
    w_victim = w_pick_fb;
    if (|w_cand_inv) begin
      w_victim = w_pick_inv;
    end else if (|w_oldest_ok) begin
      w_victim = oldest_way_array_i;
    end
  end

  assign w_evict = |(w_victim & r_valid & way_dirty_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    alloc_req_rdy_o = 1'b0;
    alloc_rsp_vld_o = 1'b0;
    w_lock_set      = '0;
    case (r_state)
      ST_IDLE: begin
        alloc_req_rdy_o = ~r_touch_pend;
        if (alloc_req_vld_i && !r_touch_pend) begin
          w_state_nxt = ST_PICK;
        end
      end
      ST_PICK: begin
        if (w_has_cand) begin
          w_lock_set  = w_victim;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        alloc_rsp_vld_o = 1'b1;
        if (alloc_rsp_rdy_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_rsp_fire    = (r_state == ST_RESP) && alloc_rsp_rdy_i;
  assign w_touch_issue = r_touch_pend && !hit_vld_i;
  assign w_fill_eff    = fill_done_vld_i ? (fill_done_way_i & r_lock) : '0;
  assign w_inval_mask  = inval_vld_i ? inval_way_i : '0;

  // Invalidate overrides a same-cycle fill; a freshly locked victim drops its valid until refilled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= '0;
      r_lock       <= '0;
      r_victim     <= '0;
      r_evict      <= 1'b0;
      r_touch_pend <= 1'b0;
    end else begin
      r_lock  <= (r_lock & ~w_fill_eff) | w_lock_set;
      r_valid <= (r_valid | w_fill_eff) & ~w_inval_mask & ~w_lock_set;
      if (|w_lock_set) begin
        r_victim <= w_victim;
        r_evict  <= w_evict;
      end
      if (w_rsp_fire && ALLOC_TOUCH) begin
        r_touch_pend <= 1'b1;
      end else if (w_touch_issue) begin
        r_touch_pend <= 1'b0;
      end
    end
  end

  // Hits win the single PLRU port; a pending allocation touch waits for a hit-free cycle.
  always_comb begin
    access_array_o = '0;
    if (hit_vld_i) begin
      access_array_o = hit_way_i;
    end else if (r_touch_pend) begin
      access_array_o = r_victim;
    end
  end

  assign alloc_rsp_way_o   = alloc_rsp_vld_o ? r_victim : '0;
  assign alloc_rsp_evict_o = alloc_rsp_vld_o & r_evict;
  assign way_locked_o      = r_lock;

  a_hit_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    hit_vld_i |-> (hit_way_i != '0) && onehot0(hit_way_i));

  a_fill_locked : assert property (@(posedge clk_i) disable iff (rst_i)
    fill_done_vld_i |-> (fill_done_way_i & ~r_lock) == '0);

endmodule

// File: tb/tb_bank_htu_victim_alloc.sv
// Directed bench for bank_htu_victim_alloc: a per-cycle vector table followed by multi-cycle allocation sequences.
module tb_bank_htu_victim_alloc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reqVld = 1'b0;
  logic       reqRdy;
  logic       rspVld;
  logic       rspRdy = 1'b0;
  logic [7:0] rspWay;
  logic       rspEvict;
  logic [7:0] dirty = 8'h00;
  logic       hitV = 1'b0;
  logic [7:0] hitW = 8'h00;
  logic       fillV = 1'b0;
  logic [7:0] fillW = 8'h00;
  logic       invV = 1'b0;
  logic [7:0] invW = 8'h00;
  logic [7:0] oldest = 8'h01;
  logic [7:0] access;
  logic [7:0] locked;

  int testsRun = 0;
  int failures = 0;

  typedef struct {
    logic       req;
    logic       rspRdy;
    logic       hitV;
    logic [7:0] hitW;
    logic       fillV;
    logic [7:0] fillW;
    logic       invV;
    logic [7:0] invW;
    logic       expRdy;
    logic       expRsp;
    logic [7:0] expWay;
    logic       expEvict;
    logic [7:0] expAccess;
    logic [7:0] expLocked;
  } vec_t;

  vec_t vecs[17];

  bank_htu_victim_alloc #(.WAYS(8), .ALLOC_TOUCH(1'b1)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .alloc_req_vld_i    (reqVld),
    .alloc_req_rdy_o    (reqRdy),
    .alloc_rsp_vld_o    (rspVld),
    .alloc_rsp_rdy_i    (rspRdy),
    .alloc_rsp_way_o    (rspWay),
    .alloc_rsp_evict_o  (rspEvict),
    .way_dirty_i        (dirty),
    .hit_vld_i          (hitV),
    .hit_way_i          (hitW),
    .fill_done_vld_i    (fillV),
    .fill_done_way_i    (fillW),
    .inval_vld_i        (invV),
    .inval_way_i        (invW),
    .oldest_way_array_i (oldest),
    .access_array_o     (access),
    .way_locked_o       (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Drives one table row at the falling edge, then samples outputs just after.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reqVld = v.req;
    rspRdy = v.rspRdy;
    hitV   = v.hitV;
    hitW   = v.hitW;
    fillV  = v.fillV;
    fillW  = v.fillW;
    invV   = v.invV;
    invW   = v.invW;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic fillWay(input logic [7:0] w);
    @(negedge clk);
    fillV = 1'b1;
    fillW = w;
    @(negedge clk);
    fillV = 1'b0;
    fillW = 8'h00;
    #1;
  endtask

  task automatic doAlloc(input string name, input logic [7:0] expWay, input logic expEvict);
    int n;
    @(negedge clk);
    reqVld = 1'b1;
    #1;
    n = 0;
    while (!reqRdy && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_rdy"}, reqRdy, 8'h01);
    @(negedge clk);
    reqVld = 1'b0;
    #1;
    n = 0;
    while (!rspVld && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_rspvld"}, rspVld, 8'h01);
    checkOutput({name, "_way"}, rspWay, expWay);
    checkOutput({name, "_evict"}, rspEvict, expEvict);
    checkOutput({name, "_lockbit"}, locked & expWay, expWay);
    rspRdy = 1'b1;
    @(negedge clk);
    rspRdy = 1'b0;
    #1;
    checkOutput({name, "_touch"}, access, expWay);
    checkOutput({name, "_rdy_touch"}, reqRdy, 8'h00);
  endtask

  initial begin
    // req rspRdy hitV hitW fillV fillW invV invW | rdy rsp way evict access locked
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 8'h01};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 8'h01};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 8'h40, 8'h02};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h40, 8'h02};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 8'h02};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h02};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h02};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 8'h00, 8'h06};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 8'h00, 8'h06};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h02, 1'b0, 1'b1, 8'h04, 1'b0, 8'h00, 8'h06};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 8'h04};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h04};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};

    doReset();
    checkOutput("reset_rdy", reqRdy, 8'h01);
    checkOutput("reset_rspvld", rspVld, 8'h00);
    checkOutput("reset_way", rspWay, 8'h00);
    checkOutput("reset_evict", rspEvict, 8'h00);
    checkOutput("reset_access", access, 8'h00);
    checkOutput("reset_locked", locked, 8'h00);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_rdy", i), reqRdy, vecs[i].expRdy);
      checkOutput($sformatf("vec%0d_rspvld", i), rspVld, vecs[i].expRsp);
      checkOutput($sformatf("vec%0d_way", i), rspWay, vecs[i].expWay);
      checkOutput($sformatf("vec%0d_evict", i), rspEvict, vecs[i].expEvict);
      checkOutput($sformatf("vec%0d_access", i), access, vecs[i].expAccess);
      checkOutput($sformatf("vec%0d_locked", i), locked, vecs[i].expLocked);
    end

    // Fill every way in order from an empty set.
    doReset();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h01 << i;
      doAlloc($sformatf("seq_fill%0d", i), w, 1'b0);
      fillWay(w);
    end

    // All valid, nothing locked: PLRU oldest way is taken.
    oldest = 8'h01;
    doAlloc("seq_oldest", 8'h01, 1'b0);
    fillWay(8'h01);

    // Dirty oldest way needs writeback and stays locked until its fill.
    dirty = 8'h10;
    oldest = 8'h10;
    doAlloc("seq_dirty", 8'h10, 1'b1);
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("seq_dirty_held", locked, 8'h10);
    end
    fillWay(8'h10);
    checkOutput("seq_dirty_unlock", locked, 8'h00);
    dirty = 8'h00;

    // Oldest way locked: fallback to lowest unlocked valid way.
    oldest = 8'h01;
    doAlloc("seq_lockA", 8'h01, 1'b0);
    oldest = 8'h04;
    doAlloc("seq_lockB", 8'h04, 1'b0);
    oldest = 8'h01;
    dirty = 8'hFF;
    doAlloc("seq_fallback", 8'h02, 1'b1);
    checkOutput("seq_fallback_locks", locked, 8'h07);
    dirty = 8'h00;
    fillWay(8'h01);
    fillWay(8'h04);
    fillWay(8'h02);

    // Lock every way, then show a request stalls in PICK until a fill frees one.
    for (int i = 0; i < 8; i++) begin
      doAlloc($sformatf("seq_lockall%0d", i), 8'h01 << i, 1'b0);
    end
    @(negedge clk);
    #1;
    checkOutput("stall_locked", locked, 8'hFF);
    reqVld = 1'b1;
    checkOutput("stall_rdy", reqRdy, 8'h01);
    @(negedge clk);
    reqVld = 1'b0;
    #1;
    checkOutput("stall_rsp0", rspVld, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("stall_rsp", rspVld, 8'h00);
      checkOutput("stall_rdy0", reqRdy, 8'h00);
    end
    @(negedge clk);
    fillV = 1'b1;
    fillW = 8'h08;
    #1;
    checkOutput("stall_fillcyc", rspVld, 8'h00);
    @(negedge clk);
    fillV = 1'b0;
    fillW = 8'h00;
    #1;
    checkOutput("stall_pick", rspVld, 8'h00);
    checkOutput("stall_freed", locked, 8'hF7);
    @(negedge clk);
    #1;
    checkOutput("stall_rsp1", rspVld, 8'h01);
    checkOutput("stall_way", rspWay, 8'h08);
    checkOutput("stall_evict", rspEvict, 8'h00);
    checkOutput("stall_relock", locked, 8'hFF);

    // Reset while a response is outstanding drops it and releases locks.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_rspvld", rspVld, 8'h00);
    checkOutput("midrst_way", rspWay, 8'h00);
    checkOutput("midrst_locked", locked, 8'h00);
    checkOutput("midrst_rdy", reqRdy, 8'h01);
    checkOutput("midrst_access", access, 8'h00);
    doAlloc("midrst_alloc", 8'h01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
